clkdv_gen_multi: RTL and testbench

- Synthesizable, parametrised successor to the behavioural clock-DLL divider model.
- Generates CHANNELS phase-aligned divided clocks plus one-cycle clock-enable pulses from a single input clock.
- Each channel has an integer divide value that can be changed at run time. Duty-cycle correction can be selected.
- Lock sequencing: outputs run only after a programmable settle time, and drop and re-lock on every reconfiguration.
- Sits in the clocking block, feeding slow-domain logic that uses enables instead of extra clock nets.

---
 rtl/clkdv_gen_multi.sv | 156 +++++++++++++++
 tb/tb_clkdv_gen_multi.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clkdv_gen_multi.sv
// clkdv_gen_multi: multi-channel integer clock divider with lock sequencing.
// Produces CHANNELS phase-aligned divided clocks and matching one-cycle
// clock enables from clkin. Outputs stay low until a programmable settle
// time has elapsed, and drop and re-lock whenever the divide values change.
module clkdv_gen_multi #(
    parameter int CHANNELS              = 4,
    parameter int DIV_W                 = 8,
    parameter int DIV_DEFAULT           = 2,
    parameter int LOCK_CYCLES           = 16,
    parameter int DUTY_CYCLE_CORRECTION = 1
) (
    input  logic                      clkin,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [CHANNELS*DIV_W-1:0] div_val,
    input  logic                      div_load,
    output logic [CHANNELS-1:0]       clkdv,
    output logic [CHANNELS-1:0]       ce,
    output logic                      locked,
    output logic                      busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOCKING = 2'd1,
        S_LOCKED  = 2'd2
    } state_t;

    localparam int               LCW       = $clog2(LOCK_CYCLES + 1);
    localparam logic [LCW-1:0]   LOCK_LAST = LCW'(LOCK_CYCLES - 1);
    localparam logic [DIV_W-1:0] N_DEF     = DIV_W'(DIV_DEFAULT);
    localparam logic [DIV_W-1:0] N_MIN     = DIV_W'(2);

    state_t           state, state_next;
    logic [LCW-1:0]   lock_cnt, lock_cnt_next;
    logic [DIV_W-1:0] n_q     [CHANNELS];
    logic [DIV_W-1:0] cnt_q   [CHANNELS];
    logic [DIV_W-1:0] cnt_nxt [CHANNELS];
    logic [CHANNELS-1:0] hi_nxt, ce_nxt;
    logic start_run, run_ch;

    // Divide values of 0 and 1 cannot form a clock, so they are raised to 2.
    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] v);
        return (v < N_MIN) ? N_MIN : v;
    endfunction

    // State and lock counter registers.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            lock_cnt <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples pre-edge values regardless of statement order.
            state    <= state_next;
            lock_cnt <= lock_cnt_next;
        end
    end

    // Next-state logic: EN low wins everywhere; a load restarts the settle time.
    always_comb begin
        // NOTE: defaults first so no branch leaves a signal unassigned,
        // which would otherwise infer a latch.
        state_next    = state;
        lock_cnt_next = lock_cnt;
        if (!en) begin
            state_next    = S_IDLE;
            lock_cnt_next = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    state_next    = S_LOCKING;
                    lock_cnt_next = '0;
                end
                S_LOCKING: begin
                    if (div_load) begin
                        lock_cnt_next = '0;
                    end else if (lock_cnt == LOCK_LAST) begin
                        state_next = S_LOCKED;
                    end else begin
                        lock_cnt_next = lock_cnt + 1'b1;
                    end
                end
                S_LOCKED: begin
                    if (div_load) begin
                        state_next    = S_LOCKING;
                        lock_cnt_next = '0;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    assign start_run = (state_next == S_LOCKED) && (state != S_LOCKED);
    assign run_ch    = (state_next == S_LOCKED) && (state == S_LOCKED);

    // Status flags registered from the next state so they align with clkdv.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            locked <= 1'b0;
            busy   <= 1'b0;
        end else begin
            locked <= (state_next == S_LOCKED);
            busy   <= (state_next == S_LOCKING);
        end
    end

    // Divide registers capture clamped values on every load, in any state.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: this small register array is reset explicitly; it holds
            // configuration, not bulk storage, so it must come up defined.
            for (int i = 0; i < CHANNELS; i++) n_q[i] <= N_DEF;
        end else if (div_load) begin
            for (int i = 0; i < CHANNELS; i++)
                n_q[i] <= clamp_div(div_val[i*DIV_W +: DIV_W]);
        end
    end

    // Per-channel next phase and the output levels that phase implies.
    always_comb begin
        hi_nxt = '0;
        ce_nxt = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_nxt[i] = (cnt_q[i] == n_q[i] - 1'b1) ? '0 : cnt_q[i] + 1'b1;
            ce_nxt[i]  = (cnt_nxt[i] == '0);
            if (DUTY_CYCLE_CORRECTION != 0)
                hi_nxt[i] = (cnt_nxt[i] < (n_q[i] - (n_q[i] >> 1)));
            else
                hi_nxt[i] = ce_nxt[i];
        end
    end

    // Channel counters and outputs: all start high together on the lock edge.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            clkdv <= '0;
            ce    <= '0;
            for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
        end else if (start_run) begin
            clkdv <= '1;
            ce    <= '1;
            for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
        end else if (run_ch) begin
            clkdv <= hi_nxt;
            ce    <= ce_nxt;
            for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= cnt_nxt[i];
        end else begin
            clkdv <= '0;
            ce    <= '0;
            for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
        end
    end

endmodule

// File: tb/tb_clkdv_gen_multi.sv
// Bench for clkdv_gen_multi: two instances (duty correction on and off)
// share stimulus; a cycle model feeds an expected-value queue that is
// popped after each edge, plus table vectors and hand-written corner cases.
module tb_clkdv_gen_multi;

    localparam int LOCK = 16;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [31:0] div_val;
    logic        div_load;
    logic [3:0]  clkdv_a, ce_a, clkdv_b, ce_b;
    logic        locked_a, busy_a, locked_b, busy_b;

    clkdv_gen_multi #(.CHANNELS(4), .DIV_W(8), .DIV_DEFAULT(2), .LOCK_CYCLES(LOCK),
                      .DUTY_CYCLE_CORRECTION(1)) dut_a (
        .clkin(clk), .rst_n(rst_n), .en(en), .div_val(div_val), .div_load(div_load),
        .clkdv(clkdv_a), .ce(ce_a), .locked(locked_a), .busy(busy_a));

    clkdv_gen_multi #(.CHANNELS(4), .DIV_W(8), .DIV_DEFAULT(2), .LOCK_CYCLES(LOCK),
                      .DUTY_CYCLE_CORRECTION(0)) dut_b (
        .clkin(clk), .rst_n(rst_n), .en(en), .div_val(div_val), .div_load(div_load),
        .clkdv(clkdv_b), .ce(ce_b), .locked(locked_b), .busy(busy_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] clkdv_a;
        logic [3:0] ce_a;
        logic [3:0] clkdv_b;
        logic [3:0] ce_b;
        logic       locked_a;
        logic       busy_a;
        logic       locked_b;
        logic       busy_b;
    } obs_t;

    typedef struct packed {
        logic [31:0]     div_val;
        logic [3:0][7:0] exp_n;
        int              lcm;
    } vec_t;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc_no   = 0;
    obs_t exp_q[$];

    int   m_mode;
    int   m_t;
    int   m_p;
    int   m_n[4];

    logic [3:0] hist_ce  [100];
    logic [3:0] hist_clk [100];
    logic [3:0] hist_clkb[100];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic obs_t sample();
        obs_t o;
        o = '{clkdv_a, ce_a, clkdv_b, ce_b, locked_a, busy_a, locked_b, busy_b};
        return o;
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_t    = 0;
        m_p    = 0;
        for (int i = 0; i < 4; i++) m_n[i] = 2;
    endtask

    // Spec-level behaviour: mode 0 idle, 1 locking (m_t edges elapsed), 2 locked (m_p cycles since lock).
    task automatic model_step(input logic e, input logic l, input logic [31:0] v);
        if (l) begin
            for (int i = 0; i < 4; i++) begin
                m_n[i] = int'(v[i*8 +: 8]);
                if (m_n[i] < 2) m_n[i] = 2;
            end
        end
        if (!e) begin
            m_mode = 0;
        end else begin
            case (m_mode)
                0: begin m_mode = 1; m_t = 0; end
                1: begin
                    if (l) m_t = 0;
                    else begin
                        m_t++;
                        if (m_t == LOCK) begin m_mode = 2; m_p = 0; end
                    end
                end
                default: begin
                    if (l) begin m_mode = 1; m_t = 0; end
                    else m_p++;
                end
            endcase
        end
    endtask

    function automatic obs_t model_out();
        obs_t o;
        o = '0;
        o.locked_a = (m_mode == 2);
        o.locked_b = (m_mode == 2);
        o.busy_a   = (m_mode == 1);
        o.busy_b   = (m_mode == 1);
        for (int i = 0; i < 4; i++) begin
            int ph;
            ph = m_p % m_n[i];
            if (m_mode == 2) begin
                o.clkdv_a[i] = (ph < (m_n[i] - (m_n[i] >> 1)));
                o.ce_a[i]    = (ph == 0);
                o.clkdv_b[i] = (ph == 0);
                o.ce_b[i]    = (ph == 0);
            end
        end
        return o;
    endfunction

    // One clock: drive inputs, push expectation, take the edge, pop and compare.
    task automatic cyc(input logic e, input logic l, input logic [31:0] v);
        obs_t exp;
        en       = e;
        div_load = l;
        div_val  = v;
        model_step(e, l, v);
        exp_q.push_back(model_out());
        @(posedge clk);
        #1;
        cyc_no++;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            exp = exp_q.pop_front();
            check($sformatf("cycle%0d", cyc_no), {12'b0, sample()}, {12'b0, exp});
        end
    endtask

    task automatic lock_with(input logic [31:0] v);
        cyc(1'b1, 1'b1, v);
        repeat (LOCK - 1) cyc(1'b1, 1'b0, v);
    endtask

    task automatic measure_lock(input logic [31:0] v, output int k);
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            cyc(1'b1, 1'b0, v);
            if (locked_a) begin k = i; break; end
        end
    endtask

    task automatic rec(input int j);
        hist_ce[j]   = ce_a;
        hist_clk[j]  = clkdv_a;
        hist_clkb[j] = clkdv_b;
    endtask

    task automatic clear_hist();
        for (int j = 0; j < 100; j++) begin
            hist_ce[j] = '0; hist_clk[j] = '0; hist_clkb[j] = '0;
        end
    endtask

    function automatic int period_of(input int ch);
        for (int j = 1; j < 100; j++) if (hist_ce[j][ch]) return j;
        return -1;
    endfunction

    initial begin
        vec_t vecs[3];
        int   k;
        int   cnt;

        vecs[0].div_val = {8'd5, 8'd4, 8'd3, 8'd0};
        vecs[0].exp_n   = {8'd5, 8'd4, 8'd3, 8'd2};
        vecs[0].lcm     = 60;
        vecs[1].div_val = {8'd0, 8'd1, 8'd2, 8'd3};
        vecs[1].exp_n   = {8'd2, 8'd2, 8'd2, 8'd3};
        vecs[1].lcm     = 6;
        vecs[2].div_val = {8'd7, 8'd6, 8'd3, 8'd2};
        vecs[2].exp_n   = {8'd7, 8'd6, 8'd3, 8'd2};
        vecs[2].lcm     = 42;

        en = 1'b0; div_load = 1'b0; div_val = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1 check("reset_state", {12'b0, sample()}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();

        // Default divide: EN at edge 0, lock at edge 16, toggling 1,0.
        cyc(1'b1, 1'b0, 32'd0);
        measure_lock(32'd0, k);
        check("default_lock_latency", k, LOCK);
        clear_hist();
        rec(0);
        for (int j = 1; j < 10; j++) begin cyc(1'b1, 1'b0, 32'd0); rec(j); end
        check("default_period_ch0", period_of(0), 2);
        check("default_clk_pattern", {hist_clk[3], hist_clk[2], hist_clk[1], hist_clk[0]}, 16'h0F0F);

        // Table vectors: reload while locked, verify clamp, period and common edges.
        for (int v = 0; v < 3; v++) begin
            lock_with(vecs[v].div_val);
            clear_hist();
            for (int j = 0; j < 70; j++) begin cyc(1'b1, 1'b0, vecs[v].div_val); rec(j); end
            check($sformatf("v%0d_all_rise_at_lock", v), hist_clk[0], 4'hF);
            check($sformatf("v%0d_all_rise_at_lcm", v), hist_clk[vecs[v].lcm], 4'hF);
            for (int ch = 0; ch < 4; ch++)
                check($sformatf("v%0d_period_ch%0d", v, ch), period_of(ch), int'(vecs[v].exp_n[ch]));
            if (v == 0) begin
                check("v0_ch2_pattern", {hist_clk[3][2], hist_clk[2][2], hist_clk[1][2], hist_clk[0][2]}, 4'b0011);
                cnt = 0;
                for (int j = 0; j < 60; j++) cnt += int'(hist_clkb[j][3]);
                check("dcc0_n5_high_count", cnt, 12);
            end
        end

        // EN low and load together: values captured, state goes idle.
        cyc(1'b0, 1'b1, 32'h04040404);
        check("en_load_idle", {30'b0, locked_a, busy_a}, 32'd0);
        cyc(1'b1, 1'b0, 32'd0);
        measure_lock(32'd0, k);
        check("en_load_relock_latency", k, LOCK);
        clear_hist();
        rec(0);
        for (int j = 1; j < 10; j++) begin cyc(1'b1, 1'b0, 32'd0); rec(j); end
        check("en_load_period_ch2", period_of(2), 4);

        // EN dropped while locked with N=7; re-raise waits the full lock time.
        lock_with(32'h07070707);
        repeat (5) cyc(1'b1, 1'b0, 32'd0);
        cyc(1'b0, 1'b0, 32'd0);
        check("en_drop_outputs", {12'b0, sample()}, 32'd0);
        cyc(1'b1, 1'b0, 32'd0);
        measure_lock(32'd0, k);
        check("en_reraise_latency", k, LOCK);
        clear_hist();
        rec(0);
        for (int j = 1; j < 16; j++) begin cyc(1'b1, 1'b0, 32'd0); rec(j); end
        check("n7_retained", period_of(0), 7);

        // Asynchronous reset mid-period at N=9, phase 4.
        lock_with(32'h09090909);
        cyc(1'b1, 1'b0, 32'd0);
        repeat (4) cyc(1'b1, 1'b0, 32'd0);
        check("pre_reset_running", {31'b0, locked_a}, 32'd1);
        #3 rst_n = 1'b0;
        #1 check("async_reset_outputs", {12'b0, sample()}, 32'd0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(1'b1, 1'b0, 32'd0);
        measure_lock(32'd0, k);
        check("post_reset_latency", k, LOCK);
        clear_hist();
        rec(0);
        for (int j = 1; j < 10; j++) begin cyc(1'b1, 1'b0, 32'd0); rec(j); end
        check("post_reset_default_n", period_of(0), 2);

        // Load during LOCKING at lock count 10 restarts the settle time.
        cyc(1'b0, 1'b0, 32'd0);
        cyc(1'b1, 1'b0, 32'd0);
        repeat (10) cyc(1'b1, 1'b0, 32'd0);
        cyc(1'b1, 1'b1, 32'h03030303);
        measure_lock(32'd0, k);
        check("load_in_locking_latency", k, LOCK);
        clear_hist();
        rec(0);
        for (int j = 1; j < 10; j++) begin cyc(1'b1, 1'b0, 32'd0); rec(j); end
        check("load_in_locking_n", period_of(1), 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
